// File: rtl/output_menu_ctrl_if.sv
// Button, source and display-side signals of the output menu controller.
interface output_menu_if;
  logic [1:0]  button;
  logic [23:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [2:0]  sel;
  logic [23:0] out;
  logic        changed;

  modport master (
    output button, in0, in1, in2, in3, in4, in5, in6, in7,
    input  sel, out, changed
  );

  modport slave (
    input  button, in0, in1, in2, in3, in4, in5, in6, in7,
    output sel, out, changed
  );
endinterface

// File: rtl/output_menu_ctrl.sv
// Output menu front-end: button sync/debounce, next/prev stepping with hold-to-repeat,
// registered source select. Optional auto-scroll mode is built when AUTO_SCROLL_EN is defined.
module output_menu_ctrl #(
  parameter int unsigned NUM_IN       = 8,
  parameter int unsigned DEB_CYCLES   = 16,
  parameter int unsigned REPEAT_DELAY = 256,
  parameter int unsigned REPEAT_RATE  = 64,
  parameter int unsigned AUTO_PERIOD  = 1024
) (
  input logic        clk,
  input logic        rst,
  output_menu_if.slave bus
);

  localparam int unsigned DW       = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {IDLE, FIRST, DELAY, REPEAT} state_t;

  logic [1:0]    sync1, sync2, deb, deb_q, press;
  state_t        state, state_nx;
  logic          dir, dir_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic          step, step_dir, held, auto_tick;
  logic [2:0]    sel_q;
  logic [23:0]   out_q, src;
  logic          chg_q;
  logic [23:0]   src_arr [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= bus.button;
      sync2 <= sync1;
      deb_q <= deb;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic          lvl;
    logic [DW-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (sync2[g] != lvl) begin
        if (32'(cnt) + 32'd1 >= DEB_CYCLES) begin
          lvl <= ~lvl;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
    assign deb[g] = lvl;
  end

  assign press = deb & ~deb_q;
  assign held  = deb[dir];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dir      <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      dir      <= dir_nx;
      hold_cnt <= hold_nx;
    end
  end

  // FIRST spends one cycle after the press step, so DELAY fires two counts early
  // to land REPEAT_DELAY cycles after the press.
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    hold_nx  = hold_cnt;
    step     = 1'b0;
    step_dir = dir;
    case (state)
      IDLE: begin
        if (press == 2'b01 || press == 2'b10) begin
          step     = 1'b1;
          step_dir = press[1];
          dir_nx   = press[1];
          state_nx = FIRST;
        end
      end
      FIRST: begin
        hold_nx  = '0;
        state_nx = held ? DELAY : IDLE;
      end
      DELAY: begin
        if (!held) begin
          state_nx = IDLE;
        end else if (32'(hold_cnt) + 32'd2 >= REPEAT_DELAY) begin
          step     = 1'b1;
          hold_nx  = '0;
          state_nx = REPEAT;
        end else begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      REPEAT: begin
        if (!held) begin
          state_nx = IDLE;
        end else if (32'(hold_cnt) + 32'd1 >= REPEAT_RATE) begin
          step    = 1'b1;
          hold_nx = '0;
        end else begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef AUTO_SCROLL_EN
  localparam int unsigned AW = $clog2(AUTO_PERIOD + 1);
  logic          auto_on, both_press, new_press, period_end;
  logic [AW-1:0] auto_cnt;

  assign both_press = (state == IDLE) && (press == 2'b11);
  assign new_press  = (state == IDLE) && (press == 2'b01 || press == 2'b10);
  assign period_end = (32'(auto_cnt) + 32'd1 >= AUTO_PERIOD);
  assign auto_tick  = auto_on && !both_press && !step && period_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_on  <= 1'b0;
      auto_cnt <= '0;
    end else begin
      if (both_press) auto_on <= ~auto_on;
      if (both_press || new_press || period_end) auto_cnt <= '0;
      else                                       auto_cnt <= auto_cnt + AW'(1);
    end
  end
`else
  assign auto_tick = 1'b0;
`endif

  function automatic logic [2:0] next_idx(input logic [2:0] s, input logic prev);
    if (prev) return (s == 3'd0) ? 3'(NUM_IN - 1) : s - 3'd1;
    else      return (32'(s) == NUM_IN - 1) ? 3'd0 : s + 3'd1;
  endfunction

  assign src_arr[0] = bus.in0;
  assign src_arr[1] = bus.in1;
  assign src_arr[2] = bus.in2;
  assign src_arr[3] = bus.in3;
  assign src_arr[4] = bus.in4;
  assign src_arr[5] = bus.in5;
  assign src_arr[6] = bus.in6;
  assign src_arr[7] = bus.in7;
  assign src = (32'(sel_q) < NUM_IN) ? src_arr[sel_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      out_q <= '0;
      chg_q <= 1'b0;
    end else begin
      out_q <= src;
      chg_q <= step | auto_tick;
      if (step)           sel_q <= next_idx(sel_q, step_dir);
      else if (auto_tick) sel_q <= next_idx(sel_q, 1'b0);
    end
  end

  assign bus.sel     = sel_q;
  assign bus.out     = out_q;
  assign bus.changed = chg_q;

endmodule
